mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit. Sits in the E stage beside the ALU.
- Owns the HI/LO registers. Executes mult/multu/div/divu with a configurable latency and also executes mthi/mtlo.
- Drives `busy` so the hazard unit can stall any later MD instruction, mfhi or mflo until the result is committed.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- MUL_CYCLES, 5: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.
- CNT_W, 8: width of the internal cycle counter; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; op, A and B are valid in the same cycle.
- op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- busy  out  1  high while a multiply or divide is in flight.
- hi  out  WIDTH  HI register; read by mfhi.
- lo  out  WIDTH  LO register; read by mflo.

Behaviour:
- Reset: synchronous on a clk edge with reset=1. Sets busy=0, hi=0, lo=0, counter=0 and FSM=IDLE. Reset overrides every other input in that cycle.
- Reset mid-operation: aborts the operation. The pending result is discarded and HI/LO go to 0.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter counting down.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}, at edge T0:
  - latch A, B and op;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - go to RUN. busy becomes 1 immediately after T0.
- RUN:
  - Each edge decrements the counter.
  - At the edge where the counter goes from 1 to 0, commit the result to hi/lo, set busy=0 and return to IDLE.
  - busy is therefore high for exactly N cycles, and hi/lo show the new values from edge T0+N.
- start while in RUN, any op: ignored. The hazard unit guarantees this does not happen; the bench still checks that the in-flight operation is undisturbed.
- MTHI or MTLO with start=1 in IDLE: hi (or lo) ← A at the same edge. busy stays 0 (single-cycle). The other register is unchanged.
- NONE or reserved op, or start=0: no state change.
- Arithmetic uses the latched operands:
  - MULT: {hi, lo} = signed A × signed B, full 2·WIDTH-bit product.
  - MULTU: {hi, lo} = unsigned A × unsigned B, full 2·WIDTH-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (A).
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Divide by zero (B=0, div or divu): the busy timing is unchanged (DIV_CYCLES), but hi and lo keep their previous values.
- Signed overflow (A = most-negative value, B = −1, DIV): lo = most-negative value (0x80000000 when WIDTH=32), hi = 0.
- Result computation may be combinational on the latched operands. Only the commit is delayed.
- hi and lo are registered outputs and never glitch during RUN.

Test Plan:
- Reset → busy=0, hi=0, lo=0. Then MTHI with A=0x12345678, followed by MTLO with A=0x9ABCDEF0 → hi=0x12345678 and lo=0x9ABCDEF0, each visible the edge after its request, with busy never asserted.
- MULT with A=0xFFFFFFFE (−2), B=3 → busy high for exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV with A=−7 (0xFFFFFFF9), B=2 → busy high for exactly 10 cycles. Then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Repeat with DIVU on A=7, B=2 → lo=3, hi=1.
- Boundary cases:
  - DIV with A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU with B=0 after hi/lo were preloaded with 0xAAAA0000/0x0000BBBB → busy for 10 cycles, then hi and lo unchanged.
- Start a MULT, then pulse start with MTLO A=0x55 on the third busy cycle → ignored. The MULT result commits at the normal time and lo is not 0x55.
- Start a DIV and assert reset on the fourth busy cycle → at that edge busy=0, hi=0, lo=0, and no later commit occurs. A new MULTU 4×5 then yields lo=20, hi=0 after 5 cycles.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; mult/div commit MUL_CYCLES/DIV_CYCLES edges after start, mthi/mtlo in one edge.
// No backpressure: busy is advisory for the hazard unit, and any start seen while busy is dropped.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Result datapath works purely on the latched request, so it is stable for the whole RUN phase.
  logic             is_signed;
  logic             is_mul;
  logic [W2-1:0]    a_ext, b_ext, prod;
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe;
  logic [WIDTH-1:0] q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (req_q.op == OP_MULT) || (req_q.op == OP_DIV);
    is_mul    = (req_q.op == OP_MULT) || (req_q.op == OP_MULTU);

    a_ext = is_signed ? {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a} : {{WIDTH{1'b0}}, req_q.a};
    b_ext = is_signed ? {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b} : {{WIDTH{1'b0}}, req_q.b};
    prod  = a_ext * b_ext;

    // Sign-magnitude division: |MIN| still fits as an unsigned magnitude, so MIN / -1 yields MIN with rem 0.
    a_neg    = is_signed && req_q.a[WIDTH-1];
    b_neg    = is_signed && req_q.b[WIDTH-1];
    a_mag    = a_neg ? (~req_q.a + WIDTH'(1)) : req_q.a;
    b_mag    = b_neg ? (~req_q.b + WIDTH'(1)) : req_q.b;
    div_zero = (req_q.b == '0);
    b_safe   = div_zero ? WIDTH'(1) : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem      = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_MULT, OP_MULTU: begin
              req_d   = '{op: op_e'(op), a: A, b: B};
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              req_d   = '{op: op_e'(op), a: A, b: B};
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (is_mul) begin
            hi_d = prod[W2-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed vector bench for mdu_unit: table of {op, operands, preload, expected HI/LO, busy length}
// plus hand-written sequences for mthi/mtlo, start-while-busy and reset mid-divide.
module tb_mdu_unit;

  localparam int W = 32;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;
  localparam logic [2:0] RSVD  = 3'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pre_hi;
    logic [W-1:0] pre_lo;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Single-cycle request; returns at the negedge after the issuing edge.
  task automatic pulse(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = NONE; A = '0; B = '0;
  endtask

  // Issues a long op and counts busy cycles; counts hi/lo changes while busy.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cycles, output int glitches);
    logic [W-1:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = NONE; A = '0; B = '0;
    cycles = 0; glitches = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (hi !== h0 || lo !== l0) glitches++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc, gl;
    logic [W-1:0] h_save, l_save;

    reset = 1'b1; start = 1'b0; op = NONE; A = '0; B = '0;

    vecs.push_back('{"mult_neg2x3",   MULT,  32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{"multu_fffe_x3", MULTU, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,        32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back('{"mult_max_sq",   MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h3FFFFFFF, 32'h00000001, 5});
    vecs.push_back('{"div_m7_2",      DIV,   32'hFFFFFFF9, 32'h2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"div_7_m2",      DIV,   32'h7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{"divu_7_2",      DIVU,  32'h7,        32'h2,        32'h0,        32'h0,        32'h00000001, 32'h00000003, 10});
    vecs.push_back('{"div_ovf",       DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h00000000, 32'h80000000, 10});
    vecs.push_back('{"divu_by0",      DIVU,  32'h1234,     32'h0,        32'hAAAA0000, 32'h0000BBBB, 32'hAAAA0000, 32'h0000BBBB, 10});
    vecs.push_back('{"div_by0",       DIV,   32'hFFFFFFF0, 32'h0,        32'h11112222, 32'h33334444, 32'h11112222, 32'h33334444, 10});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    pulse(MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'h0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    pulse(MTLO, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    pulse(NONE, 32'hDEADBEEF, 32'h1);
    pulse(RSVD, 32'hDEADBEEF, 32'h1);
    @(negedge clk);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h12345678);
    chk("nop_lo", lo, 32'h9ABCDEF0);

    foreach (vecs[i]) begin
      pulse(MTHI, vecs[i].pre_hi, 32'h0);
      pulse(MTLO, vecs[i].pre_lo, 32'h0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, gl);
      chk({vecs[i].name, "_cycles"}, W'(cyc), W'(vecs[i].exp_cycles));
      chk({vecs[i].name, "_stable"}, W'(gl), 32'd0);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // MTLO pulsed on the third busy cycle of a MULT must be ignored.
    pulse(MTHI, 32'h0, 32'h0);
    pulse(MTLO, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b1; op = MULT; A = 32'd6; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = NONE;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1; op = MTLO; A = 32'h55;
      end else begin
        start = 1'b0; op = NONE; A = '0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = NONE; A = '0;
    chk("ign_cycles", W'(cyc), 32'd5);
    chk("ign_lo", lo, 32'd42);
    chk("ign_hi", hi, 32'd0);

    // Reset on the fourth busy cycle of a DIV aborts it.
    pulse(MTHI, 32'hCAFE0001, 32'h0);
    pulse(MTLO, 32'hCAFE0002, 32'h0);
    @(negedge clk);
    start = 1'b1; op = DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = NONE;
    cyc = 0;
    while (busy && cyc < 3) begin
      cyc++;
      @(negedge clk);
    end
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    gl = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || hi !== 32'h0 || lo !== 32'h0) gl++;
    end
    chk("rst_no_commit", W'(gl), 32'd0);

    h_save = 32'h0; l_save = 32'd20;
    run_op(MULTU, 32'd4, 32'd5, cyc, gl);
    chk("post_rst_cycles", W'(cyc), 32'd5);
    chk("post_rst_hi", hi, h_save);
    chk("post_rst_lo", lo, l_save);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
